// File: rtl/pool_window_buffer.sv
// pool_window_buffer: assembles non-overlapping WINDOW x WINDOW tiles from a raster pixel stream
// into one registered, valid/ready output slot. Defining POOL_WIN_LAST_EN adds the win_last flag.
module pool_window_buffer #(
    parameter int WINDOW = 4,
    parameter int DATA_W = 32,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [WINDOW*WINDOW*DATA_W-1:0] win_data
`ifdef POOL_WIN_LAST_EN
    ,
    output logic                            win_last
`endif
);
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TILE_W = WINDOW * WINDOW * DATA_W;

    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_base;
    logic [ROW_W-1:0]  row;
    int                row_ph;
    int                col_ph;
    logic              xfer;
    logic              complete;
    logic              col_end;
    logic              row_end;
    logic [TILE_W-1:0] tile;

    logic [DATA_W-1:0] line_mem [WINDOW-1][IMG_W];
    logic [DATA_W-1:0] tail [WINDOW];

    // Handshakes: a transfer happens on a cycle where valid && ready, on either side.
    // in_ready depends only on the slot state and win_ready, never on in_valid.
    assign in_ready = !win_valid || win_ready;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        row_ph = int'(row) % WINDOW;
        col_ph = int'(col) % WINDOW;
    end

    assign col_end  = (col == COL_W'(IMG_W - 1));
    assign row_end  = (row == ROW_W'(IMG_H - 1));
    assign complete = xfer && (row_ph == WINDOW - 1) && (col_ph == WINDOW - 1);
    // Only meaningful on a completing transfer, where col sits on the tile's right edge.
    assign col_base = col - COL_W'(WINDOW - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (xfer) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Pixel storage is intentionally unreset: every entry is rewritten before a tile reads it.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int r = 0; r < WINDOW - 1; r++) begin
                if (row_ph == r) line_mem[r][col] <= in_data;
            end
            for (int c = 0; c < WINDOW; c++) begin
                if ((row_ph == WINDOW - 1) && (col_ph == c)) tail[c] <= in_data;
            end
        end
    end

    always_comb begin
        tile = '0;
        for (int r = 0; r < WINDOW - 1; r++) begin
            for (int c = 0; c < WINDOW; c++) begin
                tile[(r*WINDOW + c)*DATA_W +: DATA_W] = line_mem[r][col_base + COL_W'(c)];
            end
        end
        for (int c = 0; c < WINDOW - 1; c++) begin
            tile[((WINDOW-1)*WINDOW + c)*DATA_W +: DATA_W] = tail[c];
        end
        // The completing pixel bypasses storage and lands directly in the bottom-right element.
        tile[(WINDOW*WINDOW - 1)*DATA_W +: DATA_W] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_data  <= '0;
        end else if (complete) begin
            win_valid <= 1'b1;
            win_data  <= tile;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

`ifdef POOL_WIN_LAST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_last <= 1'b0;
        end else if (complete) begin
            win_last <= row_end && col_end;
        end
    end
`endif

endmodule

// File: tb/tb_pool_window_buffer.sv
// Self-checking bench for pool_window_buffer: a full-frame reference model feeds an expected-tile
// queue that the output monitor pops on every consumed tile.
module tb_pool_window_buffer;
    localparam int WIN    = 4;
    localparam int DW     = 32;
    localparam int IW     = 16;
    localparam int IH     = 16;
    localparam int TILE_W = WIN * WIN * DW;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              win_valid;
    logic              win_ready;
    logic [TILE_W-1:0] win_data;
`ifdef POOL_WIN_LAST_EN
    logic              win_last;
    logic              exp_last_q[$];
`endif

    logic [TILE_W-1:0] exp_q[$];
    logic [TILE_W-1:0] seen [64];
    logic [DW-1:0]     img [IH][IW];
    int                n_seen;
    int                n_last;
    int                mr;
    int                mc;
    int                checks;
    int                fails;
    int                cyc;
    logic              hold_pending;
    logic [TILE_W-1:0] hold_data;

    pool_window_buffer #(.WINDOW(WIN), .DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_data(win_data)
`ifdef POOL_WIN_LAST_EN
        ,
        .win_last(win_last)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- reference helpers ----------------
    function automatic logic [TILE_W-1:0] raster_tile(input int tr, input int tc);
        logic [TILE_W-1:0] t;
        t = '0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                t[(r*WIN + c)*DW +: DW] = DW'((tr*WIN + r)*IW + tc*WIN + c);
        return t;
    endfunction

    function automatic logic [DW-1:0] tile_max(input logic [TILE_W-1:0] t);
        logic [DW-1:0] m;
        m = t[DW-1:0];
        for (int k = 1; k < WIN*WIN; k++)
            if (t[k*DW +: DW] > m) m = t[k*DW +: DW];
        return m;
    endfunction

    task automatic clear_model();
        exp_q.delete();
`ifdef POOL_WIN_LAST_EN
        exp_last_q.delete();
`endif
        mr = 0;
        mc = 0;
        n_seen = 0;
        n_last = 0;
    endtask

    // ---------------- driver ----------------
    task automatic push_pixel(input logic [DW-1:0] d);
        logic [TILE_W-1:0] t;
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 2000) break;
        end
        if (guard > 2000) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        img[mr][mc] = d;
        if ((mr % WIN == WIN-1) && (mc % WIN == WIN-1)) begin
            t = '0;
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    t[(r*WIN + c)*DW +: DW] = img[mr-(WIN-1)+r][mc-(WIN-1)+c];
            exp_q.push_back(t);
`ifdef POOL_WIN_LAST_EN
            exp_last_q.push_back((mr == IH-1) && (mc == IW-1));
`endif
        end
        mc++;
        if (mc == IW) begin
            mc = 0;
            mr++;
            if (mr == IH) mr = 0;
        end
    endtask

    task automatic push_raster(input int n);
        for (int i = 0; i < n; i++) push_pixel(DW'(mr*IW + mc));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        win_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_empty: %0d tiles still expected, required 0", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && hold_pending) begin
            checks++;
            if (!win_valid || win_data !== hold_data) begin
                fails++;
                $display("FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h", win_valid, win_data, hold_data);
            end
        end
        hold_pending = !rst && win_valid && !win_ready;
        hold_data    = win_data;
        if (!rst && win_valid && win_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tile_unexpected: got %h, required no tile", win_data);
            end else begin
                logic [TILE_W-1:0] e;
                e = exp_q.pop_front();
                if (win_data !== e) begin
                    fails++;
                    $display("FAIL tile_data: got %h, required %h", win_data, e);
                end
`ifdef POOL_WIN_LAST_EN
                begin
                    logic el;
                    el = exp_last_q.pop_front();
                    checks++;
                    if (win_last !== el) begin
                        fails++;
                        $display("FAIL tile_last: got %0b, required %0b", win_last, el);
                    end
                    if (win_last === 1'b1) n_last++;
                end
`endif
            end
            if (n_seen < 64) seen[n_seen] = win_data;
            n_seen++;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (win_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b, required 0", win_valid); end
        checks++;
        if (win_data !== '0) begin fails++; $display("FAIL reset_data: got %h, required 0", win_data); end
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
`ifdef POOL_WIN_LAST_EN
        checks++;
        if (win_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %0b, required 0", win_last); end
`endif
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_raster_fill();
        int c0;
        do_reset();
        win_ready = 1'b1;
        c0 = cyc;
        push_raster(51);
        checks++;
        if (win_valid !== 1'b0) begin fails++; $display("FAIL fill_early_valid: got %0b, required 0", win_valid); end
        push_raster(1);
        checks++;
        if (win_valid !== 1'b1) begin fails++; $display("FAIL fill_first_valid: got %0b, required 1", win_valid); end
        checks++;
        if (win_data !== raster_tile(0, 0)) begin
            fails++;
            $display("FAIL fill_first_tile: got %h, required %h", win_data, raster_tile(0, 0));
        end
        checks++;
        if (tile_max(win_data) !== DW'(51)) begin fails++; $display("FAIL fill_pool_max: got %0d, required 51", tile_max(win_data)); end
        push_raster(IW*IH - 52);
        checks++;
        if (cyc - c0 != IW*IH) begin fails++; $display("FAIL fill_throughput: got %0d cycles, required %0d", cyc - c0, IW*IH); end
        drain();
        checks++;
        if (n_seen != 16) begin fails++; $display("FAIL fill_tile_count: got %0d, required 16", n_seen); end
        checks++;
        if (seen[15] !== raster_tile(3, 3)) begin
            fails++;
            $display("FAIL fill_last_tile: got %h, required %h", seen[15], raster_tile(3, 3));
        end
`ifdef POOL_WIN_LAST_EN
        checks++;
        if (n_last != 1) begin fails++; $display("FAIL fill_last_count: got %0d, required 1", n_last); end
`endif
    endtask

    task automatic test_backpressure();
        logic [TILE_W-1:0] held;
        do_reset();
        win_ready = 1'b0;
        push_raster(52);
        checks++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %0b, required 0", in_ready); end
        checks++;
        if (win_data !== raster_tile(0, 0)) begin
            fails++;
            $display("FAIL bp_tile0: got %h, required %h", win_data, raster_tile(0, 0));
        end
        held = raster_tile(0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (win_data !== held || win_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold: cycle %0d data=%h, required %h", i, win_data, held);
            end
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
        push_raster(IW*IH - 52);
        drain();
        checks++;
        if (n_seen != 16) begin fails++; $display("FAIL bp_tile_count: got %0d, required 16", n_seen); end
        checks++;
        if (seen[1] !== raster_tile(0, 1)) begin
            fails++;
            $display("FAIL bp_tile1: got %h, required %h", seen[1], raster_tile(0, 1));
        end
    endtask

    task automatic test_random_stall();
        bit done;
        done = 1'b0;
        do_reset();
        fork
            begin
                for (int i = 0; i < IW*IH; i++) push_pixel($urandom);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    win_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        checks++;
        if (n_seen != 16) begin fails++; $display("FAIL stall_tile_count: got %0d, required 16", n_seen); end
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset();
        win_ready = 1'b1;
        c0 = cyc;
        push_raster(2*IW*IH);
        checks++;
        if (cyc - c0 != 2*IW*IH) begin fails++; $display("FAIL b2b_throughput: got %0d cycles, required %0d", cyc - c0, 2*IW*IH); end
        drain();
        checks++;
        if (n_seen != 32) begin fails++; $display("FAIL b2b_tile_count: got %0d, required 32", n_seen); end
        checks++;
        if (seen[16] !== raster_tile(0, 0)) begin
            fails++;
            $display("FAIL b2b_frame2_first: got %h, required %h", seen[16], raster_tile(0, 0));
        end
`ifdef POOL_WIN_LAST_EN
        checks++;
        if (n_last != 2) begin fails++; $display("FAIL b2b_last_count: got %0d, required 2", n_last); end
`endif
    endtask

    task automatic async_reset_pulse();
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if (win_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid: got %0b, required 0", win_valid); end
        checks++;
        if (win_data !== '0) begin fails++; $display("FAIL async_rst_data: got %h, required 0", win_data); end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_frame_reset();
        do_reset();
        win_ready = 1'b1;
        push_raster(40);
        async_reset_pulse();
        win_ready = 1'b0;
        push_raster(52);
        checks++;
        if (win_data !== raster_tile(0, 0)) begin
            fails++;
            $display("FAIL mid_rst_first_tile: got %h, required %h", win_data, raster_tile(0, 0));
        end
        async_reset_pulse();
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready: got %0b, required 1", in_ready); end
        win_ready = 1'b1;
        push_raster(IW*IH);
        drain();
        checks++;
        if (n_seen != 16 || seen[0] !== raster_tile(0, 0)) begin
            fails++;
            $display("FAIL mid_rst_frame: count=%0d first=%h, required 16 and %h", n_seen, seen[0], raster_tile(0, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        win_ready = 1'b0;
        checks = 0;
        fails = 0;
        hold_pending = 1'b0;
        hold_data = '0;
        clear_model();
        test_reset();
        test_raster_fill();
        test_backpressure();
        test_random_stall();
        test_back_to_back();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pool_window_buffer.md
# pool_window_buffer

Streaming window-assembly stage that sits directly upstream of `max_pool`. It accepts a feature map one pixel per handshake in row-major raster order. It buffers `WINDOW-1` image rows and emits each non-overlapping `WINDOW x WINDOW` tile (stride = `WINDOW`) as one flattened vector that maps one-to-one onto `max_pool`'s `pool_input` array. Output is held in a registered, valid/ready-handshaked slot so `max_pool`, which is combinational, sees stable operands.

## Interface
- `WINDOW`, 4: window edge; must equal the `window_size` of the downstream `max_pool`.
- `DATA_W`, 32: pixel width.
- `IMG_W`, 16: pixels per row; must be a multiple of `WINDOW`.
- `IMG_H`, 16: rows per frame; must be a multiple of `WINDOW`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block can accept a pixel.
- `in_data`  in  `DATA_W`  pixel.
- `win_valid`  out  1  window slot holds a complete tile.
- `win_ready`  in  1  downstream consumes the tile.
- `win_data`  out  `WINDOW*WINDOW*DATA_W`  tile. Element `k = r*WINDOW + c` (r = row in tile, c = column in tile) sits at bits `[k*DATA_W +: DATA_W]`.
- `win_last`  out  1  present only with `POOL_WIN_LAST_EN`.

## Operation
- Transfer occurs when `in_valid && in_ready`. Counters `col` (0..`IMG_W-1`) and `row` (0..`IMG_H-1`) track the position of the accepted pixel.
- Counter update: `col` increments on each transfer. At `IMG_W-1` it wraps to 0 and `row` increments. At `row == IMG_H-1` and `col == IMG_W-1`, both wrap to 0, which starts a new frame with no idle gap.
- Line storage: `WINDOW-1` rows of `IMG_W` entries. A pixel with `row % WINDOW < WINDOW-1` is written to line `row % WINDOW` at address `col`.
- A pixel with `row % WINDOW == WINDOW-1` is not stored in the line buffer. It goes to a `WINDOW`-entry tail register at index `col % WINDOW`.
- Window completion: a transfer with `row % WINDOW == WINDOW-1` and `col % WINDOW == WINDOW-1` completes a tile.
- On the completing transfer, the output slot is loaded as follows:
  - Element `(r, c)` for `r < WINDOW-1` comes from line `r`, address `col - (WINDOW-1) + c`.
  - Elements `(WINDOW-1, c)` come from the tail register, with the incoming pixel as `c = WINDOW-1`.
- Output slot:
  - `win_valid` sets on a completing transfer.
  - `win_valid` clears on `win_valid && win_ready` unless a new completing transfer occurs in the same cycle; in that case it stays set and the slot loads the new tile.
- `in_ready = !win_valid || win_ready`. A held tile stalls input regardless of whether the next pixel completes a tile.
- Tiles per frame: `(IMG_W/WINDOW)*(IMG_H/WINDOW)` (16 at defaults).
- Reset, including mid-frame:
  - `col`, `row` and `win_valid` go to 0; `win_data` goes to 0.
  - Line and tail storage are not cleared; their contents are never observable before being rewritten.
  - The partial frame is discarded, and the first pixel after reset is row 0, col 0.

## Timing
- Reset values: `win_valid=0`, `win_data=0`, `win_last=0`; `in_ready=1` (combinational from `win_valid`).
- Latency: completing transfer in cycle N → `win_valid=1` and `win_data` valid from cycle N+1.
- `win_data` and `win_last` are stable while `win_valid && !win_ready`.
- `in_ready` has no combinational path from `in_valid`. Its only combinational input is `win_ready`.
- Throughput: one pixel per cycle sustained while `win_ready` is held high.
- Tile-to-tile spacing is at least `WINDOW` transfers, so the single output slot is sufficient.

## Configuration
- `POOL_WIN_LAST_EN` defined: port `win_last` exists.
  - It is registered alongside `win_data`.
  - It is 1 for the tile completed by pixel (`IMG_H-1`, `IMG_W-1`), and 0 for all other tiles.
- `POOL_WIN_LAST_EN` undefined: port `win_last` and its register are absent; all other behaviour is identical.

## Test plan
- **Defaults, raster fill:** feed `in_data = row*16 + col` continuously with `win_ready=1`.
  - First `win_valid` appears one cycle after the 52nd transfer (row 3, col 3).
  - `win_data` = {0,1,2,3,16,17,18,19,32,33,34,35,48,49,50,51}, k=0..15.
  - Downstream `max_pool` output is 51.
- **Full frame:** same stimulus for 256 pixels.
  - Exactly 16 tiles are produced; the last is {204..207, 220..223, 236..239, 252..255}.
  - With `POOL_WIN_LAST_EN`, `win_last=1` only on that tile.
- **Backpressure:** hold `win_ready=0` after the first tile.
  - `in_ready` drops the cycle after completion.
  - `win_data` is unchanged for 10 cycles.
  - On release, the next tile {4..7, 20..23, 36..39, 52..55} follows with no pixel lost.
- **Simultaneous consume/complete:** stream with `win_ready` high, completing a tile in the same cycle the previous tile is consumed.
  - `win_valid` stays 1.
  - Slot shows the new tile next cycle.
- **Back-to-back frames:** stream 512 pixels with no gap.
  - The second frame's first tile equals the first frame's first tile for identical data.
- **Mid-frame reset:** assert `rst` asynchronously after 40 pixels.
  - `win_valid=0` immediately.
  - Restart the raster; first tile reproduces {0..3, 16..19, 32..35, 48..51}.
